// File: rtl/tile_addr_gen_pkg.sv
// Shared definitions for the tile address generator: FSM encoding and the
// tile element count derived from the three loop bounds.
package tile_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int unsigned calc_total(input int unsigned n0,
                                             input int unsigned n1,
                                             input int unsigned n2);
    return n0 * n1 * n2;
  endfunction

endpackage

// File: rtl/tile_addr_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o whenever
// the FIFO is non-empty, and reads as zero when empty.
module tile_addr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // NOTE: sequential state uses <= so every register sees pre-edge values,
  // independent of the order in which processes are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers
  // and count, and an empty FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tile_addr_gen.sv
// Tile address generator: paces the upstream nested counter, maps each valid
// (cnt2, cnt1, cnt0) tuple to base + cnt2*stride2 + cnt1*stride1 + cnt0.
module tile_addr_gen
  import tile_addr_gen_pkg::*;
#(
  parameter int unsigned CW         = 16,
  parameter int unsigned AW         = 16,
  parameter int unsigned N0_MAX     = 4,
  parameter int unsigned N1_MAX     = 2,
  parameter int unsigned N2_MAX     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride1,
  input  logic [AW-1:0] stride2,
  output logic          cnt_ena,
  input  logic [CW-1:0] cnt0,
  input  logic [CW-1:0] cnt1,
  input  logic [CW-1:0] cnt2,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned TOTAL = calc_total(N0_MAX, N1_MAX, N2_MAX);
  localparam int unsigned CNTW  = $clog2(FIFO_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, stride1_q, stride2_q;
  logic [31:0]     vcnt_q, vcnt_d;
  logic            cnt_ena_q, cnt_ena_d;
  logic            busy_q, done_q, done_d, start_ok;

  logic            pend_q, p2_vld_q, p3_vld_q;
  logic [AW-1:0]   prod2_q, prod1_q, c0_q, sum_q;
  logic            tuple_ok, accept;
  logic [1:0]      inflight, inflight_d;

  logic [CNTW-1:0] fifo_count, fifo_count_d;
  logic            fifo_empty, fifo_pop, unused_fifo_full;

  tile_addr_fifo #(
    .WIDTH (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (p3_vld_q),
    .wdata_i (sum_q),
    .pop_i   (fifo_pop),
    .rdata_o (addr_out),
    .count_o (fifo_count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  assign addr_valid = !fifo_empty;
  assign fifo_pop   = addr_valid && addr_ready;
  assign cnt_ena    = cnt_ena_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    tuple_ok = (cnt0 < CW'(N0_MAX)) && (cnt1 < CW'(N1_MAX)) && (cnt2 < CW'(N2_MAX));
    accept   = pend_q && tuple_ok;

    inflight     = 2'(pend_q) + 2'(p2_vld_q) + 2'(p3_vld_q);
    inflight_d   = 2'(cnt_ena_q) + 2'(accept) + 2'(p2_vld_q);
    fifo_count_d = fifo_count + CNTW'(p3_vld_q) - CNTW'(fifo_pop);

    state_d  = state_q;
    vcnt_d   = vcnt_q + 32'(accept);
    done_d   = 1'b0;
    start_ok = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          vcnt_d   = '0;
          start_ok = 1'b1;
        end
      end
      ST_RUN: begin
        if (vcnt_q == TOTAL) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight == 2'd0 && fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // cnt_ena is registered, so the credit rule is evaluated on next-cycle
    // occupancy; the pulse then lands exactly when the rule holds.
    cnt_ena_d = (state_d == ST_RUN)
             && ((32'(inflight_d) + 32'(fifo_count_d)) < FIFO_DEPTH)
             && ((vcnt_d + 32'(inflight_d)) < TOTAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      vcnt_q    <= '0;
      cnt_ena_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      p2_vld_q  <= 1'b0;
      p3_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vcnt_q    <= vcnt_d;
      cnt_ena_q <= cnt_ena_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      pend_q    <= cnt_ena_q;
      p2_vld_q  <= accept;
      p3_vld_q  <= p2_vld_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      stride1_q <= '0;
      stride2_q <= '0;
      prod2_q   <= '0;
      prod1_q   <= '0;
      c0_q      <= '0;
      sum_q     <= '0;
    end else begin
      if (start_ok) begin
        base_q    <= base_addr;
        stride1_q <= stride1;
        stride2_q <= stride2;
      end
      // Products and the final sum wrap mod 2^AW by construction.
      if (accept) begin
        prod2_q <= AW'(cnt2) * stride2_q;
        prod1_q <= AW'(cnt1) * stride1_q;
        c0_q    <= AW'(cnt0);
      end
      if (p2_vld_q) sum_q <= base_q + prod2_q + prod1_q + c0_q;
    end
  end

endmodule
